// File: rtl/b16_debug_ctrl.sv
// b16_debug_ctrl
// Byte-stream debug controller for the b16 core's debug port. It decodes host
// command bytes into the core's run/dr/dw/daddr/din controls. It returns
// debug read words as two bytes (high first). It also holds a hardware
// breakpoint that halts the core on a matching bus read and reports the
// halt with an event byte (0xB0).
//
// Handshake: a byte moves on a channel only on a cycle where valid && ready
// are both high. The producer holds data stable until that cycle. Valid never
// depends on ready within a cycle.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   rx_data/valid/ready host -> controller byte channel
//   tx_data/valid/ready controller -> host byte channel
//   run, dr, dw         core run enable, debug read/write strobes
//   daddr, din          debug register select and write data
//   bp                  breakpoint address (readback by the core)
//   dout                core debug read data (valid when dr && !run)
//   addr, rd            core bus address and read strobe (breakpoint match)
//   dbg_state           current FSM state
module b16_debug_ctrl #(
  parameter int l            = 16,
  parameter bit RUN_AT_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         run,
  output logic         dr,
  output logic         dw,
  output logic [2:0]   daddr,
  output logic [l-1:0] din,
  output logic [l-1:0] bp,
  input  logic [l-1:0] dout,
  input  logic [l-1:0] addr,
  input  logic         rd,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GETHI    = 3'd1,
    S_GETLO    = 3'd2,
    S_HALTWAIT = 3'd3,
    S_ACCESS   = 3'd4,
    S_SENDHI   = 3'd5,
    S_SENDLO   = 3'd6,
    S_EVENT    = 3'd7
  } state_t;

  state_t       state, state_n;
  logic         step_q, step_n;
  logic         is_write, is_write_n;
  logic         bp_en, bp_en_n;
  logic         ev_pend, ev_pend_n;
  logic [7:0]   rdata_lo, rdata_lo_n;
  logic         run_n, dr_n, dw_n, rx_ready_n, tx_valid_n;
  logic [2:0]   daddr_n;
  logic [l-1:0] din_n, bp_n;
  logic [7:0]   tx_data_n;

  logic         rx_fire, tx_fire, hit;
  logic [1:0]   op;
  logic         f;
  logic [2:0]   sel;

  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign hit       = run && bp_en && rd && (addr == bp);
  assign op        = rx_data[7:6];
  assign f         = rx_data[5];
  assign sel       = rx_data[2:0];
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      run      <= RUN_AT_RESET;
      step_q   <= 1'b0;
      is_write <= 1'b0;
      bp_en    <= 1'b0;
      ev_pend  <= 1'b0;
      rdata_lo <= 8'h00;
      dr       <= 1'b0;
      dw       <= 1'b0;
      daddr    <= 3'd0;
      din      <= '0;
      bp       <= '1;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      rx_ready <= 1'b1;
    end else begin
      state    <= state_n;
      run      <= run_n;
      step_q   <= step_n;
      is_write <= is_write_n;
      bp_en    <= bp_en_n;
      ev_pend  <= ev_pend_n;
      rdata_lo <= rdata_lo_n;
      dr       <= dr_n;
      dw       <= dw_n;
      daddr    <= daddr_n;
      din      <= din_n;
      bp       <= bp_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      rx_ready <= rx_ready_n;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_n    = state;
    run_n      = step_q ? 1'b0 : run;  // a STEP holds run high for one clock only
    step_n     = 1'b0;
    is_write_n = is_write;
    bp_en_n    = bp_en;
    ev_pend_n  = ev_pend;
    daddr_n    = daddr;
    din_n      = din;
    bp_n       = bp;
    case (state)
      S_IDLE: begin
        if (ev_pend) begin
          state_n = S_EVENT;
        end else if (rx_fire) begin
          case (op)
            2'b00: begin
              run_n = 1'b0;
              if (f) bp_en_n = 1'b0;
            end
            2'b01: begin
              run_n  = 1'b1;
              step_n = f;
            end
            2'b10: begin
              is_write_n = 1'b0;
              daddr_n    = sel;
              if (run) begin
                run_n   = 1'b0;
                state_n = S_HALTWAIT;
              end else begin
                state_n = S_ACCESS;
              end
            end
            default: begin
              is_write_n = 1'b1;
              daddr_n    = sel;
              state_n    = S_GETHI;
            end
          endcase
        end
      end
      S_GETHI: begin
        if (rx_fire) begin
          din_n[15:8] = rx_data;
          state_n     = S_GETLO;
        end
      end
      S_GETLO: begin
        if (rx_fire) begin
          din_n[7:0] = rx_data;
          if (run) begin
            run_n   = 1'b0;
            state_n = S_HALTWAIT;
          end else begin
            state_n = S_ACCESS;
          end
        end
      end
      S_HALTWAIT: state_n = S_ACCESS;
      S_ACCESS: begin
        if (is_write) begin
          if (daddr == 3'd2) begin
            bp_n    = din;
            bp_en_n = 1'b1;
          end
          state_n = S_IDLE;
        end else begin
          state_n = S_SENDHI;
        end
      end
      S_SENDHI: if (tx_fire) state_n = S_SENDLO;
      S_SENDLO: if (tx_fire) state_n = S_IDLE;
      S_EVENT: begin
        if (tx_fire) begin
          ev_pend_n = 1'b0;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A breakpoint hit overrides any GO/STEP taken in the same cycle, and a
    // new hit re-arms the event even while the previous one is being sent.
    if (hit) begin
      run_n     = 1'b0;
      step_n    = 1'b0;
      ev_pend_n = 1'b1;
    end
  end

  // Registered outputs, derived from the next state
  always_comb begin
    rx_ready_n = ((state_n == S_IDLE) && !ev_pend_n) ||
                 (state_n == S_GETHI) || (state_n == S_GETLO);
    tx_valid_n = (state_n == S_SENDHI) || (state_n == S_SENDLO) ||
                 (state_n == S_EVENT);
    dr_n       = (state_n == S_ACCESS) && !is_write_n;
    dw_n       = (state_n == S_ACCESS) && is_write_n;
    tx_data_n  = tx_data;
    rdata_lo_n = rdata_lo;
    // tx_data only changes on state transitions, so it stays stable while
    // a byte waits for tx_ready.
    if ((state == S_ACCESS) && !is_write) begin
      tx_data_n  = dout[15:8];
      rdata_lo_n = dout[7:0];
    end else if ((state == S_SENDHI) && tx_fire) begin
      tx_data_n = rdata_lo;
    end else if ((state != S_EVENT) && (state_n == S_EVENT)) begin
      tx_data_n = 8'hB0;
    end
  end

endmodule

// File: tb/tb_b16_debug_ctrl.sv
module tb_b16_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        run, dr, dw;
  logic [2:0]  daddr;
  logic [15:0] din, bp, dout, addr;
  logic        rd;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int dw_count = 0;
  int dw_base;

  b16_debug_ctrl #(.l(16), .RUN_AT_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .run(run), .dr(dr), .dw(dw), .daddr(daddr), .din(din), .bp(bp),
    .dout(dout), .addr(addr), .rd(rd), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  always @(posedge clk) if (dw) dw_count <= dw_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte; returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (rx_ready) tick();
    else check("rx_timeout", {31'd0, rx_ready}, 32'd1);
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    dout = 16'h0000; addr = 16'h0000; rd = 1'b0;
    tick(); tick();

    // 1: reset values, then HALT
    check("rst_run", run, 1);
    check("rst_bp", bp, 16'hFFFF);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_strobes", {dr, dw}, 0);
    check("rst_din", din, 0);
    check("rst_daddr", daddr, 0);
    reset = 1'b0;
    tick();
    send_byte(8'h00);
    check("halt_run", run, 0);

    // 2: READ P while halted, with tx back-pressure
    dout = 16'h1234;
    send_byte(8'h84);
    check("rd_dr", dr, 1);
    check("rd_daddr", daddr, 4);
    check("rd_txv_c1", tx_valid, 0);
    tick();
    check("rd_dr_off", dr, 0);
    check("rd_txv_hi", tx_valid, 1);
    check("rd_hi", tx_data, 8'h12);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_hi_hold", {tx_valid, tx_data}, {1'b1, 8'h12});
    end
    tx_ready = 1'b1;
    tick();
    check("rd_lo", {tx_valid, tx_data}, {1'b1, 8'h34});
    tick();
    check("rd_done", tx_valid, 0);
    tx_ready = 1'b0;

    // 3: WRITE while running goes through HALTWAIT
    send_byte(8'h40);
    check("go_run", run, 1);
    send_byte(8'hC4);
    send_byte(8'h3F);
    send_byte(8'hFE);
    check("wr_run_drop", run, 0);
    check("wr_haltwait", {dw, dbg_state}, {1'b0, 3'd3});
    tick();
    check("wr_dw", dw, 1);
    check("wr_daddr", daddr, 4);
    check("wr_din", din, 16'h3FFE);
    tick();
    check("wr_dw_off", dw, 0);

    // READ while running: one extra cycle
    tx_ready = 1'b1;
    dout = 16'hABCD;
    send_byte(8'h40);
    send_byte(8'h85);
    check("rdr_c1", {run, dr}, 0);
    tick();
    check("rdr_dr", {dr, daddr}, {1'b1, 3'd5});
    tick();
    check("rdr_hi", {tx_valid, tx_data}, {1'b1, 8'hAB});
    tick();
    check("rdr_lo", {tx_valid, tx_data}, {1'b1, 8'hCD});
    tick();
    check("rdr_done", tx_valid, 0);
    tx_ready = 1'b0;

    // 4: set breakpoint at 0100, run onto it
    send_byte(8'hC2);
    send_byte(8'h01);
    send_byte(8'h00);
    check("bp_dw", {dw, daddr}, {1'b1, 3'd2});
    tick();
    check("bp_set", bp, 16'h0100);
    send_byte(8'h40);
    check("bp_go", run, 1);
    rd = 1'b1; addr = 16'h0100;
    tick();
    check("bp_halt", run, 0);
    check("bp_rx_block", rx_ready, 0);
    rd = 1'b0;
    tick();
    check("bp_event", {tx_valid, tx_data}, {1'b1, 8'hB0});
    tx_ready = 1'b1;
    tick();
    check("bp_event_done", tx_valid, 0);
    tx_ready = 1'b0;
    // disarm and run past the old address
    send_byte(8'h20);
    send_byte(8'h40);
    rd = 1'b1; addr = 16'h0100;
    tick(); tick();
    check("bp_disarmed", {run, tx_valid}, {1'b1, 1'b0});
    rd = 1'b0;
    send_byte(8'h00);
    check("halt2", run, 0);

    // 5: STEP, plain then onto the re-armed breakpoint
    send_byte(8'hC2);
    send_byte(8'h01);
    send_byte(8'h00);
    tick();
    send_byte(8'h60);
    check("step_on", run, 1);
    tick();
    check("step_off", run, 0);
    tick();
    check("step_no_ev", tx_valid, 0);
    rd = 1'b1; addr = 16'h0100;
    send_byte(8'h60);
    check("stepbp_on", run, 1);
    tick();
    check("stepbp_off", run, 0);
    rd = 1'b0;
    tick();
    check("stepbp_event", {tx_valid, tx_data}, {1'b1, 8'hB0});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("stepbp_done", tx_valid, 0);

    // 6: reset in the middle of a WRITE
    dw_base = dw_count;
    send_byte(8'hC3);
    send_byte(8'h12);
    reset = 1'b1;
    #1;
    check("mid_rst_state", dbg_state, 0);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("mid_rst_no_dw", dw_count - dw_base, 0);
    check("mid_rst_run", run, 1);
    check("mid_rst_bp", bp, 16'hFFFF);
    send_byte(8'h00);
    check("fresh_halt", {run, dbg_state}, 0);
    tick(); tick();
    check("fresh_no_dw", dw_count - dw_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/b16_debug_ctrl.md
# b16_debug_ctrl

Byte-stream debug controller placed directly upstream of the b16 core's debug port. It turns host commands from a UART-style byte channel into the core's `run`, `dr`, `dw`, `daddr` and `din` controls, returns `dout` words as byte pairs, and holds a hardware breakpoint. The breakpoint halts the core on a matching bus read and sends an event byte to the host.

## Interface
- `l`, 16: data width. Only 16 is supported.
- `RUN_AT_RESET`, 1: value of `run` out of reset.
- `clk` in 1: the single clock, shared with the core.
- `reset` in 1: asynchronous, active-high.
- `rx_data` in 8: command or data byte from the host.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: a byte is accepted on a cycle where `rx_valid && rx_ready`.
- `tx_data` out 8: byte to the host.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: a byte is consumed on a cycle where `tx_valid && tx_ready`.
- `run` out 1: core run enable.
- `dr` out 1: debug read strobe to the core.
- `dw` out 1: debug write strobe to the core.
- `daddr` out 3: debug register select.
- `din` out 16: debug write data.
- `bp` out 16: breakpoint address, fed to the core for readback.
- `dout` in 16: core debug read data. Valid only when `dr && !run`.
- `addr` in 16: core bus address.
- `rd` in 1: core bus read strobe.

## Operation
**Command byte format:** `op = rx_data[7:6]`, `f = rx_data[5]`, `sel = rx_data[2:0]`. Bits [4:3] are ignored.

**Opcodes:**
- `op 00` HALT: `run <= 0`. If `f = 1`, the breakpoint is also disarmed (`bp_en <= 0`).
- `op 01` GO:
  - `f = 0`: `run <= 1`.
  - `f = 1` (STEP): `run` is high for exactly one clock, then low.
- `op 10` READ `sel`:
  - Ensure halted, then pulse `dr` for one cycle with `daddr = sel`, and capture `dout` on that same edge.
  - Transmit the high byte, then the low byte.
  - Reading `sel` 0 or 1 pops the corresponding core stack. This is the core's behaviour and is not masked here.
- `op 11` WRITE `sel`:
  - Receive the high byte, then the low byte, into `din`.
  - Ensure halted, then pulse `dw` for one cycle with `daddr = sel`.
  - If `sel == 2`: also `bp <= din` and `bp_en <= 1` on that same edge.

**Ensure halted:** if `run = 1` when the core access is due, drop `run` and wait one cycle (state HALTWAIT). `dr`/`dw` are asserted only while `run = 0`.

**Breakpoint:**
- Hit condition: `run && bp_en && rd && addr == bp`.
- On a hit: `run <= 0` on the next edge and set `ev_pend`.
- A STEP whose single cycle matches the breakpoint also sets `ev_pend`. `run` is low afterwards in either case.

**Event byte:** when the FSM is in IDLE and `ev_pend = 1`, send 0xB0 and clear `ev_pend` when it is accepted. Event bytes never interleave within a two-byte READ reply.

**FSM states:** IDLE, GETHI, GETLO, HALTWAIT, ACCESS, SENDHI, SENDLO, EVENT.
- IDLE: `rx_ready = 1` unless `ev_pend`, in which case go to EVENT.
  - HALT / GO: execute, stay in IDLE.
  - READ: go to HALTWAIT if `run`, else ACCESS.
  - WRITE: go to GETHI.
- GETHI → GETLO, each on an accepted byte.
- GETLO → HALTWAIT or ACCESS, on an accepted byte.
- HALTWAIT → ACCESS.
- ACCESS (one cycle, strobe asserted): READ → SENDHI; WRITE → IDLE.
- SENDHI → SENDLO → IDLE, each on `tx_ready`.
- EVENT → IDLE, on `tx_ready`.

**Handshake outputs:**
- `rx_ready` is high only in IDLE (with no event pending), GETHI and GETLO.
- `tx_valid` is high only in SENDHI, SENDLO and EVENT.
- `tx_data` is held stable while `tx_valid && !tx_ready`.

## Timing
**Reset values:**
- `run = RUN_AT_RESET`
- `dr = dw = 0`, `daddr = 0`, `din = 0`
- `bp = 16'hFFFF`, `bp_en = 0`, `ev_pend = 0`
- `tx_valid = 0`, `tx_data = 0`
- `rx_ready = 1`; FSM in IDLE

**Reset mid-operation:** a partially received WRITE or a pending reply is discarded. No strobe is emitted after `reset` asserts.

**All outputs are registered.**

**Latencies:**
- HALT/GO take effect on `run` in the cycle after the byte is accepted.
- READ while halted:
  - Byte accepted at edge 0.
  - `dr` high in cycle 1.
  - `tx_valid` with the high byte in cycle 2.
- READ while running: one extra cycle (HALTWAIT).
- WRITE: `dw` is high in the cycle after the low byte is accepted (plus one if running).
- Breakpoint: `run` is low in the cycle after the matching `rd && addr == bp`.

**Simultaneous events:**
- Breakpoint hit in the same cycle a GO is accepted: the hit wins, and `run` ends low.
- Breakpoint hit in the same cycle a HALT is accepted: `run` ends low, and `ev_pend` is still set.

**Event coalescing:** `ev_pend` is a single flag. Multiple hits before transmission yield one 0xB0.

## Test plan
1. Reset with `RUN_AT_RESET = 1` → `run = 1`, `bp = FFFF`, `tx_valid = 0`. Send 0x00 → `run = 0` one cycle later.
2. Halted, `dout = 16'h1234`; send 0x84 (READ P) → `dr` high one cycle with `daddr = 4`, then `tx` bytes 0x12 then 0x34. Holding `tx_ready = 0` for 3 cycles keeps 0x12 stable.
3. Running; send 0xC4, 0x3F, 0xFE → `run` drops, HALTWAIT, then `dw` one cycle with `daddr = 4`, `din = 3FFE`.
4. Send 0xC2, 0x01, 0x00, then 0x40; drive `rd = 1`, `addr = 0100` → `run = 0` next cycle, `tx` 0xB0. Send 0x20 → a later `addr = 0100` read causes no halt.
5. Halted; send 0x60 (STEP) → `run` high exactly one cycle. A STEP onto the breakpoint also yields 0xB0.
6. Assert `reset` between the two data bytes of a WRITE → no `dw` pulse; the next command is parsed fresh from IDLE.
